// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usr_pkg
// Description : Shared definitions for the universal shift register.
//               Provides the operation-mode codes and the burst FSM state
//               encoding used by univ_shift_reg and usr_next_val.
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

  // Single-cycle operation codes (the mode input)
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASHR = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  // Burst FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BURST = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage : usr_pkg
`default_nettype wire

// File: rtl/usr_next_val.sv
`default_nettype none
// ============================================================================
// Module      : usr_next_val
// Description : Combinational next-value function of the shift register.
//               Ports:
//                 q        - current register contents
//                 mode     - operation select (see usr_pkg MODE_*)
//                 d        - parallel load data
//                 ser_in_l - bit entering the LSB on a left shift
//                 ser_in_r - bit entering the MSB on a right shift
//                 q_nxt    - value the register takes if this op is applied
// Revision    : 1.0 - initial release
// ============================================================================
module usr_next_val
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q_nxt
);

  always_comb begin
    q_nxt = q;
    case (mode)
      MODE_LOAD: q_nxt = d;
      MODE_SHL:  q_nxt = {q[WIDTH-2:0], ser_in_l};
      MODE_SHR:  q_nxt = {ser_in_r, q[WIDTH-1:1]};
      MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
      MODE_ASHR: q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      default:   q_nxt = q;  // hold and the reserved code
    endcase
  end

endmodule : usr_next_val
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg
// Description : WIDTH-bit universal shift register with load/shift/rotate/
//               arithmetic-shift modes and an autonomous burst shifter.
//               Ports:
//                 clk, reset          - clock, async active-high reset
//                 clr                 - sync clear to RESET_VAL, aborts burst
//                 en, mode, d         - single-cycle operation control
//                 ser_in_l, ser_in_r  - serial fill bits for shl / shr
//                 start, burst_len,
//                 burst_dir           - burst request (0 = left, 1 = right)
//                 q                   - register contents
//                 ser_out_l/ser_out_r - q MSB / q LSB
//                 busy, done          - burst in progress / burst finished
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [CW-1:0]    burst_len,
  input  logic             burst_dir,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  localparam logic [CW-1:0] c_width = CW'(WIDTH);
  localparam logic [CW-1:0] c_one   = CW'(1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic             r_dir,   w_dir_nxt;
  logic [WIDTH-1:0] r_q,     w_q_nxt;

  logic [2:0]       w_nv_mode;
  logic             w_nv_sl;
  logic             w_nv_sr;
  logic [WIDTH-1:0] w_nv_q;

  // During a burst the shared next-value function is steered to a plain
  // logical shift with zero fill in the latched direction.
  always_comb begin
    w_nv_mode = mode;
    w_nv_sl   = ser_in_l;
    w_nv_sr   = ser_in_r;
    if (r_state == S_BURST) begin
      w_nv_mode = r_dir ? MODE_SHR : MODE_SHL;
      w_nv_sl   = 1'b0;
      w_nv_sr   = 1'b0;
    end
  end

  usr_next_val #(
    .WIDTH (WIDTH)
  ) u_next_val (
    .q        (r_q),
    .mode     (w_nv_mode),
    .d        (d),
    .ser_in_l (w_nv_sl),
    .ser_in_r (w_nv_sr),
    .q_nxt    (w_nv_q)
  );

  // Next-state logic; priority: clr, burst activity, start, en/mode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_q_nxt     = r_q;
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_q_nxt     = RESET_VAL;
    end else begin
      case (r_state)
        S_BURST: begin
          w_q_nxt   = w_nv_q;
          w_cnt_nxt = r_cnt - c_one;
          if (r_cnt == c_one) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin  // S_IDLE (and any unused encoding)
          if (start) begin
            if (burst_len == '0) begin
              w_state_nxt = S_DONE;
            end else begin
              // Lengths beyond WIDTH saturate: the result is all zeros anyway.
              w_cnt_nxt   = (burst_len > c_width) ? c_width : burst_len;
              w_dir_nxt   = burst_dir;
              w_state_nxt = S_BURST;
            end
          end else if (en) begin
            w_q_nxt = w_nv_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_q     <= RESET_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_q     <= w_q_nxt;
    end
  end

  assign q         = r_q;
  assign ser_out_l = r_q[WIDTH-1];
  assign ser_out_r = r_q[0];
  assign busy      = (r_state == S_BURST);
  assign done      = (r_state == S_DONE);

endmodule : univ_shift_reg
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_univ_shift_reg
// Description : Self-checking bench for univ_shift_reg (WIDTH=8,
//               RESET_VAL=0) with an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, clr, en, ser_in_l, ser_in_r, start, burst_dir;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic [CW-1:0] burst_len;
  logic [W-1:0]  q;
  logic          ser_out_l, ser_out_r, busy, done;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model state
  int unsigned m_q;
  int          m_left;
  bit          m_busy, m_done, m_dir;

  univ_shift_reg #(
    .WIDTH     (W),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .en        (en),
    .mode      (mode),
    .d         (d),
    .ser_in_l  (ser_in_l),
    .ser_in_r  (ser_in_r),
    .start     (start),
    .burst_len (burst_len),
    .burst_dir (burst_dir),
    .q         (q),
    .ser_out_l (ser_out_l),
    .ser_out_r (ser_out_r),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_left = 0; m_busy = 0; m_done = 0; m_dir = 0;
  endtask

  // One clock edge of the reference model, from the current inputs.
  task automatic model_step();
    int unsigned n;
    if (clr) begin
      m_q = 0; m_left = 0; m_busy = 0; m_done = 0;
    end else if (m_busy) begin
      m_q    = m_dir ? (m_q >> 1) : ((m_q << 1) & 'hFF);
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (start) begin
      n = (burst_len > W) ? W : burst_len;
      if (n == 0) m_done = 1;
      else begin
        m_busy = 1; m_left = n; m_dir = burst_dir;
      end
    end else if (en) begin
      case (mode)
        3'd1: m_q = d;
        3'd2: m_q = ((m_q << 1) | ser_in_l) & 'hFF;
        3'd3: m_q = (m_q >> 1) | (ser_in_r << 7);
        3'd4: m_q = ((m_q << 1) | (m_q >> 7)) & 'hFF;
        3'd5: m_q = (m_q >> 1) | ((m_q & 1) << 7);
        3'd6: m_q = (m_q >> 1) | (m_q & 'h80);
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},    q,         m_q);
    chk({tag, ".busy"}, busy,      m_busy);
    chk({tag, ".done"}, done,      m_done);
    chk({tag, ".sol"},  ser_out_l, (m_q >> 7) & 1);
    chk({tag, ".sor"},  ser_out_r, m_q & 1);
  endtask

  // Inputs are stable across the edge; the model advances with the DUT.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    clr = 0; en = 0; mode = 3'd0; d = '0; ser_in_l = 0; ser_in_r = 0;
    start = 0; burst_len = '0; burst_dir = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    reset = 0;

    // Async reset in the middle of a burst, checked before any clock edge
    en = 1; mode = 3'd1; d = 8'hA5; tick("ld_a5");
    en = 0; start = 1; burst_len = 4'd5; burst_dir = 0; tick("st5");
    start = 0;
    #2 reset = 1;
    #1;
    model_reset();
    chk("async_rst.q", q, 8'h00);
    chk("async_rst.busy", busy, 1'b0);
    chk("async_rst.done", done, 1'b0);
    reset = 0;
    tick("post_rst");

    // Load, shl, shr
    en = 1; mode = 3'd1; d = 8'h96; tick("ld96");
    mode = 3'd2; ser_in_l = 1; tick("shl");
    chk("shl_val", q, 8'h2D);
    mode = 3'd3; ser_in_r = 0; tick("shr");
    chk("shr_val", q, 8'h16);

    // Rotates, ashr, reserved code, en=0
    mode = 3'd1; d = 8'h81; tick("ld81");
    mode = 3'd4; tick("rol");  chk("rol_val", q, 8'h03);
    mode = 3'd5; tick("ror");  chk("ror_val", q, 8'h81);
    mode = 3'd6; tick("ashr"); chk("ashr_val", q, 8'hC0);
    mode = 3'd7; tick("rsvd"); chk("rsvd_val", q, 8'hC0);
    en = 0; mode = 3'd1; d = 8'h5A; tick("en0"); chk("en0_val", q, 8'hC0);

    // 3-shift left burst; a load request while busy is ignored
    en = 1; mode = 3'd1; d = 8'h01; tick("ld01");
    en = 0; start = 1; burst_len = 4'd3; burst_dir = 0; tick("b3_start");
    start = 0; en = 1; mode = 3'd1; d = 8'hFF;
    tick("b3_c1"); tick("b3_c2"); tick("b3_c3");
    chk("b3_q", q, 8'h08);
    chk("b3_done", done, 1'b1);
    en = 0;
    tick("b3_idle");

    // Zero-length burst, then full-length right burst
    start = 1; burst_len = 4'd0; tick("b0");
    chk("b0_done", done, 1'b1);
    start = 0; tick("b0_idle");
    en = 1; mode = 3'd1; d = 8'hB7; tick("ldb7");
    en = 0; start = 1; burst_len = 4'd8; burst_dir = 1; tick("b8_start");
    start = 0;
    for (int i = 0; i < 8; i++) tick("b8_run");
    chk("b8_q", q, 8'h00);
    tick("b8_idle");

    // Saturated length (15 -> 8)
    en = 1; mode = 3'd1; d = 8'hFF; tick("ldff");
    en = 0; start = 1; burst_len = 4'd15; burst_dir = 0; tick("b15_start");
    start = 0;
    for (int i = 0; i < 9; i++) tick("b15_run");

    // clr in the 2nd cycle of a 5-shift burst
    en = 1; mode = 3'd1; d = 8'h3C; tick("ld3c");
    en = 0; start = 1; burst_len = 4'd5; burst_dir = 1; tick("c5_start");
    start = 0; tick("c5_c1");
    clr = 1; tick("c5_clr");
    chk("clr_q", q, 8'h00);
    chk("clr_busy", busy, 1'b0);
    clr = 0; tick("c5_after");
    chk("clr_nodone", done, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      clr       = ($urandom_range(0, 24) == 0);
      start     = ($urandom_range(0, 6) == 0);
      en        = $urandom_range(0, 1);
      mode      = 3'($urandom_range(0, 7));
      d         = 8'($urandom);
      ser_in_l  = $urandom_range(0, 1);
      ser_in_r  = $urandom_range(0, 1);
      burst_len = 4'($urandom_range(0, 15));
      burst_dir = $urandom_range(0, 1);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule : tb_univ_shift_reg
`default_nettype wire
